// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Accepts 12-bit ALU commands over valid/ready and owns an 8 x DATA_W register file.
//   For each command it reads the operands, issues one request to an external ALU,
//   waits for the result (with a timeout) and writes it back. Only one command is in flight.
//   Command word: [11:9] op (ADD, SUB, AND, OR, NOT, 101-111 NOP), [8:6] src1, [5:3] src2, [2:0] dst.
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   cmd_valid / cmd_ready / cmd     command handshake (ready only while idle)
//   alu_req, alu_op_code,
//   alu_a, alu_b                    request pulse and operands to the external ALU
//   alu_done, alu_result            ALU response, sampled only while waiting
//   reg_wr_en/addr/data             external preload port, accepted every cycle
//   reg_rd_addr / reg_rd_data       combinational debug read port
//   busy, done, timeout_err         status: not idle, retire pulse, sticky timeout flag
module alu_cmd_sequencer #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [11:0]       cmd,
    output logic              alu_req,
    output logic [2:0]        alu_op_code,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              reg_wr_en,
    input  logic [2:0]        reg_wr_addr,
    input  logic [DATA_W-1:0] reg_wr_data,
    input  logic [2:0]        reg_rd_addr,
    output logic [DATA_W-1:0] reg_rd_data,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    localparam int unsigned NREGS = 8;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [2:0]  OP_NOT = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t              state_q;
    logic                cmd_ready_q;
    logic                busy_q;
    logic                done_q;
    logic                alu_req_q;
    logic [2:0]          alu_op_q;
    logic [DATA_W-1:0]   alu_a_q;
    logic [DATA_W-1:0]   alu_b_q;
    logic                timeout_err_q;
    logic [2:0]          dst_q;
    logic                have_res_q;
    logic [DATA_W-1:0]   res_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   regs_q [NREGS];

    // Command field decode
    logic [2:0] cmd_op;
    logic [2:0] cmd_src1;
    logic [2:0] cmd_src2;
    logic [2:0] cmd_dst;
    logic       accept;

    assign cmd_op   = cmd[11:9];
    assign cmd_src1 = cmd[8:6];
    assign cmd_src2 = cmd[5:3];
    assign cmd_dst  = cmd[2:0];
    assign accept   = cmd_valid && cmd_ready_q;

    // Sequencer, register file and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            alu_req_q     <= 1'b0;
            alu_op_q      <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            timeout_err_q <= 1'b0;
            dst_q         <= '0;
            have_res_q    <= 1'b0;
            res_q         <= '0;
            cnt_q         <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            // Preload first so a writeback to the same address in this cycle overrides it
            if (reg_wr_en) begin
                regs_q[reg_wr_addr] <= reg_wr_data;
            end

            done_q    <= 1'b0;
            alu_req_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        dst_q       <= cmd_dst;
                        have_res_q  <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (cmd_op <= OP_NOT) begin
                            // Operands are snapshotted here; later preloads cannot disturb them
                            state_q   <= S_ISSUE;
                            alu_req_q <= 1'b1;
                            alu_op_q  <= cmd_op;
                            alu_a_q   <= regs_q[cmd_src1];
                            alu_b_q   <= (cmd_op == OP_NOT) ? '0 : regs_q[cmd_src2];
                        end else begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                        end
                    end
                end

                S_ISSUE: begin
                    state_q <= S_WAIT;
                    cnt_q   <= '0;
                end

                S_WAIT: begin
                    if (alu_done) begin
                        res_q      <= alu_result;
                        have_res_q <= 1'b1;
                        state_q    <= S_FINISH;
                        done_q     <= 1'b1;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        // This was the last allowed WAIT cycle
                        timeout_err_q <= 1'b1;
                        state_q       <= S_FINISH;
                        done_q        <= 1'b1;
                    end else if (cnt_q != CNT_W'(TIMEOUT)) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_FINISH: begin
                    if (have_res_q) begin
                        regs_q[dst_q] <= res_q;
                    end
                    have_res_q  <= 1'b0;
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    alu_op_q    <= '0;
                    alu_a_q     <= '0;
                    alu_b_q     <= '0;
                end

                default: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign alu_req     = alu_req_q;
    assign alu_op_code = alu_op_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign timeout_err = timeout_err_q;
    assign reg_rd_data = regs_q[reg_rd_addr];

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer
//   Drives directed and random commands into alu_cmd_sequencer, plays the external ALU,
//   and compares every cycle against a register-array reference model of the sequencer.
module tb_alu_cmd_sequencer;

    localparam int unsigned DW  = 32;
    localparam int          TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [11:0]   cmd;
    logic          alu_req;
    logic [2:0]    alu_op_code;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic          alu_done;
    logic [DW-1:0] alu_result;
    logic          reg_wr_en;
    logic [2:0]    reg_wr_addr;
    logic [DW-1:0] reg_wr_data;
    logic [2:0]    reg_rd_addr;
    logic [DW-1:0] reg_rd_data;
    logic          busy;
    logic          done;
    logic          timeout_err;

    alu_cmd_sequencer #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd        (cmd),
        .alu_req    (alu_req),
        .alu_op_code(alu_op_code),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .reg_wr_en  (reg_wr_en),
        .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data),
        .reg_rd_addr(reg_rd_addr),
        .reg_rd_data(reg_rd_data),
        .busy       (busy),
        .done       (done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] mregs [8];
    bit          exp_terr;
    bit          pend_en;
    logic [2:0]  pend_addr;
    logic [31:0] pend_data;
    bit          rand_pre;
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            default: return ~a;
        endcase
    endfunction

    // Advance one clock; preloads driven this cycle land in the model at the edge
    task automatic tick();
        @(posedge clk);
        if (pend_en) mregs[pend_addr] = pend_data;
        pend_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic preload_set(input logic [2:0] addr, input logic [31:0] data);
        reg_wr_en   = 1'b1;
        reg_wr_addr = addr;
        reg_wr_data = data;
        pend_en     = 1'b1;
        pend_addr   = addr;
        pend_data   = data;
    endtask

    task automatic preload_rand();
        if (rand_pre && $urandom_range(0, 3) == 0) begin
            preload_set(3'($urandom), $urandom);
        end else begin
            reg_wr_en = 1'b0;
            pend_en   = 1'b0;
        end
    endtask

    task automatic check_reg(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        reg_rd_addr = addr;
        #1;
        check_eq(tag, reg_rd_data, exp);
    endtask

    task automatic check_rd();
        logic [2:0] a;
        a = 3'($urandom);
        check_reg("rd_port", a, mregs[a]);
    endtask

    // Inputs while the sequencer is busy: optionally hold the next command, junk ALU strobes
    task automatic drive_busy(input bit hold, input logic [11:0] nxt);
        cmd_valid  = hold ? 1'b1 : 1'($urandom);
        cmd        = hold ? nxt : 12'($urandom);
        alu_done   = 1'($urandom);
        alu_result = $urandom;
    endtask

    // One command from acceptance to return-to-idle. lat = WAIT cycle that answers, 0 = never.
    task automatic run_cmd(input logic [11:0] c, input int lat, input bit hold,
                           input logic [11:0] nxt, input bit clash);
        logic [2:0]  op, s1, s2, d;
        logic [31:0] ea, eb, er;
        bit          tmo;
        op = c[11:9]; s1 = c[8:6]; s2 = c[5:3]; d = c[2:0];

        // cycle 0: idle, accept
        check_eq("idle_ready", 32'(cmd_ready), 32'd1);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_a", alu_a, 32'd0);
        check_rd();
        ea = mregs[s1];
        eb = (op == 3'd4) ? 32'd0 : mregs[s2];
        cmd_valid = 1'b1;
        cmd       = c;
        alu_done  = 1'b0;
        preload_rand();
        tick();

        if (op > 3'd4) begin
            check_eq("nop_done", 32'(done), 32'd1);
            check_eq("nop_req", 32'(alu_req), 32'd0);
            check_eq("nop_ready", 32'(cmd_ready), 32'd0);
            check_rd();
            drive_busy(hold, nxt);
            preload_rand();
            tick();
            if (!hold) cmd_valid = 1'b0;
            alu_done  = 1'b0;
            reg_wr_en = 1'b0;
            check_eq("nop_ready2", 32'(cmd_ready), 32'd1);
            check_eq("nop_done2", 32'(done), 32'd0);
            check_rd();
            return;
        end

        // cycle 1: issue
        check_eq("issue_req", 32'(alu_req), 32'd1);
        check_eq("issue_op", 32'(alu_op_code), 32'(op));
        check_eq("issue_a", alu_a, ea);
        check_eq("issue_b", alu_b, eb);
        check_eq("issue_ready", 32'(cmd_ready), 32'd0);
        check_eq("issue_busy", 32'(busy), 32'd1);
        check_eq("issue_done", 32'(done), 32'd0);
        check_rd();
        drive_busy(hold, nxt);
        preload_rand();
        er  = alu_fn(op, ea, eb);
        tmo = 1'b0;

        for (int w = 1; w <= TMO; w++) begin
            tick();
            check_eq("wait_req", 32'(alu_req), 32'd0);
            check_eq("wait_done", 32'(done), 32'd0);
            check_eq("wait_ready", 32'(cmd_ready), 32'd0);
            check_eq("wait_op", 32'(alu_op_code), 32'(op));
            check_eq("wait_a", alu_a, ea);
            check_eq("wait_b", alu_b, eb);
            check_eq("wait_terr", 32'(timeout_err), 32'(exp_terr));
            check_rd();
            drive_busy(hold, nxt);
            preload_rand();
            if (w == lat) begin
                alu_done   = 1'b1;
                alu_result = er;
                break;
            end
            alu_done = 1'b0;
            if (w == TMO) tmo = 1'b1;
        end

        // finish
        tick();
        if (tmo) exp_terr = 1'b1;
        check_eq("fin_done", 32'(done), 32'd1);
        check_eq("fin_busy", 32'(busy), 32'd1);
        check_eq("fin_op", 32'(alu_op_code), 32'(op));
        check_eq("fin_terr", 32'(timeout_err), 32'(exp_terr));
        check_rd();
        drive_busy(hold, nxt);
        if (clash) preload_set(d, 32'h0000_00AA);
        else       preload_rand();
        tick();
        if (!tmo) mregs[d] = er;

        // back in idle
        if (!hold) cmd_valid = 1'b0;
        alu_done  = 1'b0;
        reg_wr_en = 1'b0;
        check_eq("end_done", 32'(done), 32'd0);
        check_eq("end_ready", 32'(cmd_ready), 32'd1);
        check_eq("end_busy", 32'(busy), 32'd0);
        check_eq("end_op", 32'(alu_op_code), 32'd0);
        check_eq("end_a", alu_a, 32'd0);
        check_eq("end_b", alu_b, 32'd0);
        check_eq("end_terr", 32'(timeout_err), 32'(exp_terr));
        check_reg("writeback", d, mregs[d]);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_req"}, 32'(alu_req), 32'd0);
        check_eq({tag, "_op"}, 32'(alu_op_code), 32'd0);
        check_eq({tag, "_a"}, alu_a, 32'd0);
        check_eq({tag, "_b"}, alu_b, 32'd0);
        check_eq({tag, "_terr"}, 32'(timeout_err), 32'd0);
        for (int i = 0; i < 8; i++) check_reg({tag, "_reg"}, 3'(i), 32'd0);
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        reg_wr_en = 1'b0;
        pend_en   = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) mregs[i] = 32'd0;
        exp_terr = 1'b0;
    endtask

    // Reset lands while a command is waiting; a late alu_done must not resurrect it
    task automatic reset_mid_wait();
        cmd_valid = 1'b1;
        cmd       = 12'b000_001_010_011;
        reg_wr_en = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        apply_reset();
        alu_done   = 1'b1;
        alu_result = 32'h1234_5678;
        check_reset_state("mid_rst");
        tick();
        alu_done = 1'b0;
        check_eq("post_rst_done", 32'(done), 32'd0);
        check_eq("post_rst_busy", 32'(busy), 32'd0);
        check_reg("post_rst_r3", 3'd3, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

    initial begin
        logic [11:0] cmds [61];
        int          lat;

        rst = 1'b1; cmd_valid = 1'b0; cmd = '0; alu_done = 1'b0; alu_result = '0;
        reg_wr_en = 1'b0; reg_wr_addr = '0; reg_wr_data = '0; reg_rd_addr = '0;
        rand_pre = 1'b0; pend_en = 1'b0; exp_terr = 1'b0;
        @(negedge clk);
        tick();
        apply_reset();
        check_reset_state("rst");

        // ADD r3 = r1 + r2
        preload_set(3'd1, 32'd5); tick();
        preload_set(3'd2, 32'd3); tick();
        run_cmd(12'b000_001_010_011, 1, 1'b0, 12'd0, 1'b0);
        check_reg("add_r3", 3'd3, 32'd8);

        // NOT r5 = ~r4, operand B forced to zero
        preload_set(3'd4, 32'h0000_FFFF); tick();
        run_cmd(12'b100_100_000_101, 3, 1'b0, 12'd0, 1'b0);
        check_reg("not_r5", 3'd5, 32'hFFFF_0000);

        // NOP leaves r1 alone
        run_cmd(12'b111_010_110_001, 0, 1'b0, 12'd0, 1'b0);
        check_reg("nop_r1", 3'd1, 32'd5);

        // Timeout, then a normal SUB
        run_cmd(12'b000_001_010_110, 0, 1'b0, 12'd0, 1'b0);
        check_eq("tmo_sticky", 32'(timeout_err), 32'd1);
        check_reg("tmo_r6", 3'd6, 32'd0);
        run_cmd(12'b001_011_001_111, 2, 1'b0, 12'd0, 1'b0);
        check_reg("sub_r7", 3'd7, 32'd3);
        check_eq("tmo_still", 32'(timeout_err), 32'd1);

        // Answer in the very last WAIT cycle is not a timeout
        run_cmd(12'b011_001_010_000, TMO, 1'b0, 12'd0, 1'b0);

        // Held cmd_valid: second command waits for idle, src == dst
        preload_set(3'd1, 32'd7); tick();
        run_cmd(12'b000_010_011_100, 1, 1'b1, 12'b000_001_001_001, 1'b0);
        run_cmd(12'b000_001_001_001, 1, 1'b0, 12'd0, 1'b0);
        check_reg("dbl_r1", 3'd1, 32'd14);

        // Writeback beats a same-cycle preload to the same register
        preload_set(3'd6, 32'd4); tick();
        preload_set(3'd7, 32'd5); tick();
        run_cmd(12'b000_110_111_011, 1, 1'b0, 12'd0, 1'b1);
        check_reg("clash_r3", 3'd3, 32'd9);

        reset_mid_wait();

        // Random commands with random preloads, latencies and back-to-back holds
        rand_pre = 1'b1;
        for (int i = 0; i < 61; i++) cmds[i] = 12'($urandom);
        for (int i = 0; i < 60; i++) begin
            lat = $urandom_range(1, TMO);
            if ($urandom_range(0, 9) == 0) lat = 0;
            run_cmd(cmds[i], lat, 1'($urandom), cmds[i + 1], 1'($urandom_range(0, 7) == 0));
        end
        cmd_valid = 1'b0;
        reg_wr_en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
